measure_clifford: RTL and testbench

Single-shot Pauli-product measurement engine for a 5-qubit register held in a product of single-qubit stabilizer states. Each frame it captures a per-qubit measurement basis and a per-qubit prepared state, then resolves each qubit's outcome serially, one qubit per cycle. Outcomes are deterministic when the basis matches the state axis and LFSR-random otherwise. The block then presents the outcome bits, their product eigenvalue and a determinism flag. It runs free-running between a stabilizer-state source and a downstream result consumer, with no start input.

---
 rtl/measure_clifford_pkg.sv | 47 ++++
 rtl/measure_clifford_lfsr.sv | 27 ++
 rtl/measure_clifford.sv | 138 +++++++++++++
 tb/tb_measure_clifford.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/measure_clifford_pkg.sv
// Shared encodings, FSM states and per-qubit resolution rule for the
// single-shot Pauli-product measurement engine.
package measure_clifford_pkg;

  localparam int NUM_QUBITS = 5;
  localparam int IDX_W      = 3;
  localparam int VALUE_W    = NUM_QUBITS + 2;

  typedef enum logic [1:0] {
    BASIS_I = 2'b00,
    BASIS_X = 2'b01,
    BASIS_Y = 2'b10,
    BASIS_Z = 2'b11
  } basis_e;

  typedef enum logic [1:0] {
    ST_ZP = 2'b00,
    ST_ZM = 2'b01,
    ST_XP = 2'b10,
    ST_XM = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FSM_CAPTURE = 2'b00,
    FSM_SCAN    = 2'b01,
    FSM_DONE    = 2'b10
  } fsm_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 when shifting toward bit 0
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Returns {deterministic, outcome}; the state's low bit is its eigenvalue sign
  function automatic logic [1:0] resolve_qubit(input logic [1:0] basis,
                                               input logic [1:0] st,
                                               input logic       rnd);
    logic [1:0] r;
    r = {1'b0, rnd};
    case (basis)
      BASIS_I: r = 2'b10;
      BASIS_Z: if (st == ST_ZP || st == ST_ZM) r = {1'b1, st[0]};
      BASIS_X: if (st == ST_XP || st == ST_XM) r = {1'b1, st[0]};
      default: r = {1'b0, rnd};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/measure_clifford_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; supplies the random outcome bit for
// measurements whose basis does not match the prepared state axis.
module clifford_lfsr16
  import measure_clifford_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  output logic rnd_bit
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  assign lfsr_next = {^(lfsr_reg & LFSR_TAPS), lfsr_reg[15:1]};
  assign rnd_bit   = lfsr_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

endmodule

// File: rtl/measure_clifford.sv
// Captures per-qubit bases and states, resolves one qubit per cycle, then
// strobes the outcome bits with their product parity and determinism flag.
module measure_clifford
  import measure_clifford_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_basis_0,
  input  logic [1:0]         i_basis_1,
  input  logic [1:0]         i_basis_2,
  input  logic [1:0]         i_basis_3,
  input  logic [1:0]         i_basis_4,
  input  logic [1:0]         i_result_0,
  input  logic [1:0]         i_result_1,
  input  logic [1:0]         i_result_2,
  input  logic [1:0]         i_result_3,
  input  logic [1:0]         i_result_4,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_QUBITS - 1);

  fsm_e state_reg, state_next;

  logic [NUM_QUBITS-1:0][1:0] basis_in, result_in;
  logic [NUM_QUBITS-1:0][1:0] basis_reg, result_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic [NUM_QUBITS-1:0]      bits_reg, bits_next;
  logic                       parity_reg, parity_next;
  logic                       det_reg, det_next;
  logic [VALUE_W-1:0]         value_reg;

  logic [NUM_QUBITS-1:0] lane_outcome;
  logic [NUM_QUBITS-1:0] lane_det;
  logic [NUM_QUBITS-1:0] lane_active;
  logic                  rnd_bit;
  logic                  sel_outcome, sel_det, sel_active;
  logic                  scan_last;

  assign basis_in  = {i_basis_4, i_basis_3, i_basis_2, i_basis_1, i_basis_0};
  assign result_in = {i_result_4, i_result_3, i_result_2, i_result_1, i_result_0};

  clifford_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .rnd_bit (rnd_bit)
  );

  // Every lane is resolved in parallel; the scan index picks one per cycle
  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUBITS; gi++) begin : g_lane
      logic [1:0] res;
      assign res              = resolve_qubit(basis_reg[gi], result_reg[gi], rnd_bit);
      assign lane_det[gi]     = res[1];
      assign lane_outcome[gi] = res[0];
      assign lane_active[gi]  = (basis_reg[gi] != BASIS_I);
    end
  endgenerate

  assign sel_outcome = lane_outcome[idx_reg];
  assign sel_det     = lane_det[idx_reg];
  assign sel_active  = lane_active[idx_reg];
  assign scan_last   = (idx_reg == LAST_IDX);

  always_comb begin
    bits_next          = bits_reg;
    bits_next[idx_reg] = sel_outcome;
    parity_next        = parity_reg ^ (sel_outcome & sel_active);
    det_next           = det_reg & sel_det;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= FSM_CAPTURE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FSM_CAPTURE: state_next = FSM_SCAN;
      FSM_SCAN:    if (scan_last) state_next = FSM_DONE;
      FSM_DONE:    state_next = FSM_CAPTURE;
      default:     state_next = FSM_CAPTURE;
    endcase
  end

  always_comb begin
    o_ready = (state_reg == FSM_DONE);
  end

  // Datapath: capture, serial accumulation and the single result write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      basis_reg  <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
      bits_reg   <= '0;
      parity_reg <= 1'b0;
      det_reg    <= 1'b1;
      value_reg  <= '0;
    end else begin
      case (state_reg)
        FSM_CAPTURE: begin
          basis_reg  <= basis_in;
          result_reg <= result_in;
          idx_reg    <= '0;
          bits_reg   <= '0;
          parity_reg <= 1'b0;
          det_reg    <= 1'b1;
        end
        FSM_SCAN: begin
          bits_reg   <= bits_next;
          parity_reg <= parity_next;
          det_reg    <= det_next;
          if (scan_last) begin
            idx_reg   <= '0;
            value_reg <= {det_next, parity_next, bits_next};
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_value = value_reg;

endmodule

// File: tb/tb_measure_clifford.sv
// Directed bench for measure_clifford: frame timing, deterministic and
// random outcomes, input isolation and asynchronous reset behaviour.
module tb_measure_clifford;

  logic       clk;
  logic       rst_n;
  logic [4:0][1:0] tb_basis;
  logic [4:0][1:0] tb_state;
  logic [6:0] o_value;
  logic       o_ready;

  int errors;
  int checks;

  measure_clifford #(
    .LFSR_SEED (16'hACE1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_basis_0  (tb_basis[0]),
    .i_basis_1  (tb_basis[1]),
    .i_basis_2  (tb_basis[2]),
    .i_basis_3  (tb_basis[3]),
    .i_basis_4  (tb_basis[4]),
    .i_result_0 (tb_state[0]),
    .i_result_1 (tb_state[1]),
    .i_result_2 (tb_state[2]),
    .i_result_3 (tb_state[3]),
    .i_result_4 (tb_state[4]),
    .o_value    (o_value),
    .o_ready    (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Holds reset for two edges and releases on a falling edge so the next
  // rising edge is edge 1 (CAPTURE) of the first frame.
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tb_basis = '0;
    tb_state = '0;
    rst_n    = 1'b0;
    #25;
    checks++;
    if (o_value !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_value: got %b expected %b", o_value, 7'b0000000);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", o_ready);
    end
    checks++;
    if (dut.u_lfsr.lfsr_reg !== 16'hACE1) begin
      errors++;
      $display("FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.lfsr_reg);
    end
    $display("reset: value=%b ready=%b lfsr=%h", o_value, o_ready, dut.u_lfsr.lfsr_reg);
  endtask

  task automatic test_all_z();
    logic exp_ready;
    tb_basis = {5{2'b11}};
    tb_state = {2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    apply_reset();
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      exp_ready = (e == 6 || e == 13);
      checks++;
      if (o_ready !== exp_ready) begin
        errors++;
        $display("FAIL all_z_ready_edge%0d: got %b expected %b", e, o_ready, exp_ready);
      end
      if (exp_ready) begin
        checks++;
        if (o_value !== 7'b1111010) begin
          errors++;
          $display("FAIL all_z_value_edge%0d: got %b expected %b", e, o_value, 7'b1111010);
        end
        $display("all_z: edge %0d value=%b", e, o_value);
      end
      // Frame 2 was captured on edge 8; this change must not reach it
      if (e == 8) tb_basis = '0;
    end
  endtask

  task automatic test_all_i();
    tb_basis = '0;
    tb_state = {2'b11, 2'b01, 2'b10, 2'b01, 2'b11};
    apply_reset();
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #1;
      if (e == 6 || e == 13) begin
        checks++;
        if (o_ready !== 1'b1 || o_value !== 7'b1000000) begin
          errors++;
          $display("FAIL all_i_edge%0d: got ready=%b value=%b expected ready=1 value=%b",
                   e, o_ready, o_value, 7'b1000000);
        end
        $display("all_i: edge %0d value=%b", e, o_value);
      end
      if (e == 7) tb_state = {2'b00, 2'b10, 2'b11, 2'b00, 2'b01};
    end
  endtask

  task automatic test_all_x();
    tb_basis = {5{2'b01}};
    tb_state = {5{2'b11}};
    apply_reset();
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      #1;
      if (e == 6) begin
        checks++;
        if (o_value !== 7'b1111111) begin
          errors++;
          $display("FAIL all_x_minus: got %b expected %b", o_value, 7'b1111111);
        end
        $display("all_x minus: value=%b", o_value);
        tb_state = {5{2'b10}};
      end
      if (e == 12) begin
        checks++;
        if (o_value !== 7'b1111111) begin
          errors++;
          $display("FAIL all_x_hold: got %b expected %b", o_value, 7'b1111111);
        end
      end
      if (e == 13) begin
        checks++;
        if (o_value !== 7'b1000000) begin
          errors++;
          $display("FAIL all_x_plus: got %b expected %b", o_value, 7'b1000000);
        end
        $display("all_x plus: value=%b", o_value);
      end
    end
  endtask

  task automatic test_mixed();
    logic [15:0] s;
    logic [4:0]  rnd_at;
    tb_basis = {2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    tb_state = {2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    // Qubit k is resolved on edge k+2, after k+1 LFSR steps from the seed
    s = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      s = lfsr_step(s);
      rnd_at[k] = s[0];
    end
    apply_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (o_value[6] !== 1'b0) begin
      errors++;
      $display("FAIL mixed_det: got %b expected 0", o_value[6]);
    end
    checks++;
    if (o_value[3:2] !== 2'b11) begin
      errors++;
      $display("FAIL mixed_bits32: got %b expected 11", o_value[3:2]);
    end
    checks++;
    if (o_value[5] !== ^o_value[4:0]) begin
      errors++;
      $display("FAIL mixed_parity: got %b expected %b", o_value[5], ^o_value[4:0]);
    end
    checks++;
    if ({o_value[4], o_value[1], o_value[0]} !== {rnd_at[4], rnd_at[1], rnd_at[0]}) begin
      errors++;
      $display("FAIL mixed_random: got %b expected %b",
               {o_value[4], o_value[1], o_value[0]}, {rnd_at[4], rnd_at[1], rnd_at[0]});
    end
    $display("mixed: value=%b lfsr bits q4,q1,q0=%b%b%b", o_value, rnd_at[4], rnd_at[1], rnd_at[0]);
  endtask

  task automatic test_reset_mid_scan();
    logic exp_ready;
    tb_basis = {5{2'b11}};
    tb_state = {2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    apply_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (o_value !== 7'b1111010) begin
      errors++;
      $display("FAIL mid_pre_value: got %b expected %b", o_value, 7'b1111010);
    end
    // Edges 7..10 bring the second frame to SCAN with idx=2
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_value !== 7'b0000000 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got value=%b ready=%b expected value=0000000 ready=0",
               o_value, o_ready);
    end
    $display("mid_scan reset: value=%b ready=%b", o_value, o_ready);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      exp_ready = (e == 6);
      checks++;
      if (o_ready !== exp_ready) begin
        errors++;
        $display("FAIL mid_restart_ready_edge%0d: got %b expected %b", e, o_ready, exp_ready);
      end
      if (e == 6) begin
        checks++;
        if (o_value !== 7'b1111010) begin
          errors++;
          $display("FAIL mid_restart_value: got %b expected %b", o_value, 7'b1111010);
        end
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    tb_basis = '0;
    tb_state = '0;
    test_reset();
    test_all_z();
    test_all_i();
    test_all_x();
    test_mixed();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
